// File: rtl/processor_fifo_pkg.sv
// Shared constants for the stream-to-register FIFO: register map, STATUS bit
// positions and a width helper for pointer/level sizing.
package processor_fifo_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_LEVEL   = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_THRESH  = 3'd3;
  localparam logic [2:0] ADDR_DROP    = 3'd4;
  localparam logic [2:0] ADDR_CTRL    = 3'd5;
  localparam logic [2:0] ADDR_LAST_CH = 3'd6;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_UNF   = 3;
  localparam int ST_IRQ   = 4;

  // Ceiling log2; a depth of N entries needs clog2(N) pointer bits.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/processor_sync_fifo_core.sv
// Generic single-clock FIFO. A pop on empty is ignored; a push while full is
// only accepted when a pop frees a slot in the same cycle; flush beats push.
module processor_sync_fifo_core
  import processor_fifo_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int DEPTH = 16,
  localparam int AW   = clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] q,
  output logic [LW-1:0]    level,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign level = level_q;
  assign q     = mem_q[rd_ptr_q];

  // Accept decisions and next pointer/level state.
  always_comb begin
    pop_ok   = pop & ~empty;
    push_ok  = push & ~flush & (~full | pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(push_ok) - LW'(pop_ok);
    end
  end

  // Pointer and level registers; reset discards the contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; data needs no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/processor_st_to_mm_fifo_csr.sv
// Streaming sink to register-mapped read slave. Buffers tagged samples and
// exposes pop, level, sticky flags, threshold irq, drop counter and flush.
module processor_st_to_mm_fifo_csr
  import processor_fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CH_W   = 4,
  parameter int DROP_W = 16
) (
  input  logic              wrclock,
  input  logic              reset,
  input  logic [DATA_W-1:0] avalonst_sink_data,
  input  logic [CH_W-1:0]   avalonst_sink_channel,
  input  logic              avalonst_sink_valid,
  input  logic [2:0]        avalonmm_slave_address,
  input  logic              avalonmm_slave_read,
  input  logic              avalonmm_slave_write,
  input  logic [31:0]       avalonmm_slave_writedata,
  output logic [31:0]       avalonmm_slave_readdata,
  output logic              irq
);

  localparam int LW    = clog2(DEPTH) + 1;
  localparam int WIDTH = DATA_W + CH_W;
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  logic [WIDTH-1:0]  fifo_q;
  logic [LW-1:0]     fifo_level;
  logic              fifo_empty, fifo_full;
  logic              pop, flush, ovf_evt, unf_evt;

  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [LW-1:0]     threshold_q, threshold_d;
  logic [CH_W-1:0]   last_ch_q, last_ch_d;
  logic              irq_q, irq_d;
  logic [31:0]       readdata_q, readdata_d;
  logic [31:0]       status;
  logic [DROP_W-1:0] drop_base;

  // A DATA read requests a pop; CONTROL bit0 flushes.
  assign pop   = avalonmm_slave_read  && (avalonmm_slave_address == ADDR_DATA);
  assign flush = avalonmm_slave_write && (avalonmm_slave_address == ADDR_CTRL)
                 && avalonmm_slave_writedata[0];

  processor_sync_fifo_core #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_core (
    .clk   (wrclock),
    .rst   (reset),
    .push  (avalonst_sink_valid),
    .wdata ({avalonst_sink_data, avalonst_sink_channel}),
    .pop   (pop),
    .flush (flush),
    .q     (fifo_q),
    .level (fifo_level),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // A full FIFO is never empty, so any pop frees a slot; flush discards silently.
  assign ovf_evt = avalonst_sink_valid & fifo_full & ~pop & ~flush;
  assign unf_evt = pop & fifo_empty;

  // CSR next state: sticky flags (set beats clear), counter, threshold, read mux.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (avalonmm_slave_write && avalonmm_slave_address == ADDR_STATUS) begin
      if (avalonmm_slave_writedata[ST_OVF]) overflow_d  = 1'b0;
      if (avalonmm_slave_writedata[ST_UNF]) underflow_d = 1'b0;
    end
    if (ovf_evt) overflow_d  = 1'b1;
    if (unf_evt) underflow_d = 1'b1;

    drop_base = (avalonmm_slave_write && avalonmm_slave_address == ADDR_DROP) ? '0 : drop_q;
    drop_d    = drop_base;
    if (ovf_evt && drop_base != DROP_MAX) drop_d = drop_base + DROP_W'(1);

    threshold_d = threshold_q;
    if (avalonmm_slave_write && avalonmm_slave_address == ADDR_THRESH) begin
      if (avalonmm_slave_writedata > 32'(DEPTH)) threshold_d = LW'(DEPTH);
      else threshold_d = avalonmm_slave_writedata[LW-1:0];
    end

    last_ch_d = last_ch_q;
    if (pop && !fifo_empty) last_ch_d = fifo_q[CH_W-1:0];

    irq_d = (fifo_level >= threshold_q) || overflow_q;

    status           = '0;
    status[ST_EMPTY] = fifo_empty;
    status[ST_FULL]  = fifo_full;
    status[ST_OVF]   = overflow_q;
    status[ST_UNF]   = underflow_q;
    status[ST_IRQ]   = irq_q;

    readdata_d = readdata_q;
    if (avalonmm_slave_read) begin
      case (avalonmm_slave_address)
        ADDR_DATA:    readdata_d = fifo_empty ? '0 : 32'(fifo_q[WIDTH-1:CH_W]);
        ADDR_LEVEL:   readdata_d = 32'(fifo_level);
        ADDR_STATUS:  readdata_d = status;
        ADDR_THRESH:  readdata_d = 32'(threshold_q);
        ADDR_DROP:    readdata_d = 32'(drop_q);
        ADDR_LAST_CH: readdata_d = 32'(last_ch_q);
        default:      readdata_d = '0;
      endcase
    end
  end

  // CSR state registers.
  always_ff @(posedge wrclock or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      drop_q      <= '0;
      threshold_q <= LW'(DEPTH / 2);
      last_ch_q   <= '0;
      irq_q       <= 1'b0;
      readdata_q  <= '0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      drop_q      <= drop_d;
      threshold_q <= threshold_d;
      last_ch_q   <= last_ch_d;
      irq_q       <= irq_d;
      readdata_q  <= readdata_d;
    end
  end

  assign avalonmm_slave_readdata = readdata_q;
  assign irq                     = irq_q;

endmodule
